// File: rtl/esc_pkg.sv
// rtl/esc_pkg.sv - shared state, gate-pattern and command encodings for the ESC bridge stage
package esc_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DEAD  = 3'd1,
    FWD   = 3'd2,
    REV   = 3'd3,
    FAULT = 3'd4
  } state_t;

  // Gate patterns are ordered {ah, al, bh, bl}.
  localparam logic [3:0] GATES_OFF   = 4'b0000;
  localparam logic [3:0] GATES_FWD   = 4'b1001;
  localparam logic [3:0] GATES_REV   = 4'b0110;
  localparam logic [3:0] GATES_BRAKE = 4'b0101;

  localparam logic [1:0] CMD_IDLE    = 2'b00;
  localparam logic [1:0] CMD_REV     = 2'b01;
  localparam logic [1:0] CMD_FWD     = 2'b10;
  localparam logic [1:0] CMD_ILLEGAL = 2'b11;

  function automatic logic [3:0] gate_pattern(input state_t s, input logic brake);
    logic [3:0] p;
    case (s)
      IDLE:    p = brake ? GATES_BRAKE : GATES_OFF;
      FWD:     p = GATES_FWD;
      REV:     p = GATES_REV;
      default: p = GATES_OFF;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/esc_sync.sv
// rtl/esc_sync.sv - single-bit multi-flop synchronizer for asynchronous inputs
module esc_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= (sync_q << 1) | STAGES'(d);
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/hbridge_deadtime_driver.sv
// rtl/hbridge_deadtime_driver.sv - H-bridge gate driver with dead-time insertion and fault latch
module hbridge_deadtime_driver
  import esc_pkg::*;
#(
  parameter int DT_WIDTH    = 8,
  parameter int DT_MIN      = 1,
  parameter int SYNC_STAGES = 2,
  parameter int FCNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  pos_in,
  input  logic                  neg_in,
  input  logic                  brake_en,
  input  logic [DT_WIDTH-1:0]   dead_time,
  input  logic                  ext_fault,
  input  logic                  fault_clear,
  output logic                  gate_ah,
  output logic                  gate_al,
  output logic                  gate_bh,
  output logic                  gate_bl,
  output logic                  fault,
  output logic [FCNT_WIDTH-1:0] fault_count
);

  logic fault_sync;

  esc_sync #(.STAGES(SYNC_STAGES)) u_fault_sync (
    .clk   (clk),
    .reset (reset),
    .d     (ext_fault),
    .q     (fault_sync)
  );

  state_t                state_q, state_d;
  state_t                target_q, target_d;
  logic                  tgt_brake_q, tgt_brake_d;
  logic [DT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [FCNT_WIDTH-1:0] fcnt_q, fcnt_d;
  logic [3:0]            gates_q;
  logic                  fault_q;

  logic [1:0]          cmd;
  logic                dec_brake;
  state_t              dec_state;
  logic [3:0]          dec_gates;
  logic [DT_WIDTH-1:0] dt_load;
  logic                fault_req;

  // A disabled bridge decodes as coast regardless of the PWM inputs.
  assign cmd       = enable ? {pos_in, neg_in} : CMD_IDLE;
  assign dec_brake = enable & brake_en;
  assign dt_load   = (dead_time < DT_WIDTH'(DT_MIN)) ? DT_WIDTH'(DT_MIN) : dead_time;
  assign fault_req = (cmd == CMD_ILLEGAL) | fault_sync;

  always_comb begin
    dec_state = IDLE;
    case (cmd)
      CMD_FWD: dec_state = FWD;
      CMD_REV: dec_state = REV;
      default: dec_state = IDLE;
    endcase
  end

  assign dec_gates = gate_pattern(dec_state, dec_brake);

  // Targets are compared by gate pattern so that coast and brake idle count as distinct.
  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    tgt_brake_d = tgt_brake_q;
    cnt_d       = cnt_q;
    fcnt_d      = fcnt_q;
    if (state_q == FAULT) begin
      if (fault_clear && !fault_sync && (cmd == CMD_IDLE)) begin
        state_d     = DEAD;
        target_d    = IDLE;
        tgt_brake_d = dec_brake;
        cnt_d       = dt_load;
      end
    end else if (fault_req) begin
      state_d = FAULT;
      if (fcnt_q != '1) begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end else if (state_q == DEAD) begin
      if (dec_gates != gate_pattern(target_q, tgt_brake_q)) begin
        target_d    = dec_state;
        tgt_brake_d = dec_brake;
        cnt_d       = dt_load;
      end else if (cnt_q <= DT_WIDTH'(1)) begin
        state_d = target_q;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end else if (dec_gates != gates_q) begin
      state_d     = DEAD;
      target_d    = dec_state;
      tgt_brake_d = dec_brake;
      cnt_d       = dt_load;
    end
  end

  // Gates decode from the next state so they switch on the same edge as the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      target_q    <= IDLE;
      tgt_brake_q <= 1'b0;
      cnt_q       <= '0;
      fcnt_q      <= '0;
      gates_q     <= GATES_OFF;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      tgt_brake_q <= tgt_brake_d;
      cnt_q       <= cnt_d;
      fcnt_q      <= fcnt_d;
      gates_q     <= gate_pattern(state_d, tgt_brake_d);
      fault_q     <= (state_d == FAULT);
    end
  end

  assign gate_ah     = gates_q[3];
  assign gate_al     = gates_q[2];
  assign gate_bh     = gates_q[1];
  assign gate_bl     = gates_q[0];
  assign fault       = fault_q;
  assign fault_count = fcnt_q;

endmodule

// File: tb/tb_hbridge_deadtime_driver.sv
// tb/tb_hbridge_deadtime_driver.sv - scoreboard bench for hbridge_deadtime_driver
module tb_hbridge_deadtime_driver;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0, pos_in = 1'b0, neg_in = 1'b0, brake_en = 1'b0;
  logic [7:0] dead_time = 8'd0;
  logic       ext_fault = 1'b0, fault_clear = 1'b0;
  logic       gate_ah, gate_al, gate_bh, gate_bl, fault;
  logic [7:0] fault_count;

  hbridge_deadtime_driver dut (
    .clk(clk), .reset(reset), .enable(enable), .pos_in(pos_in), .neg_in(neg_in),
    .brake_en(brake_en), .dead_time(dead_time), .ext_fault(ext_fault),
    .fault_clear(fault_clear), .gate_ah(gate_ah), .gate_al(gate_al),
    .gate_bh(gate_bh), .gate_bl(gate_bl), .fault(fault), .fault_count(fault_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] g;
    logic       f;
    logic [7:0] c;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   mon_on = 0;

  // Reference model: conduction pattern plus absolute release time of a pending dead interval.
  bit         hist[$];
  int         cyc, release_at, m_fcnt;
  bit         m_fault, dead;
  logic [3:0] cur, goal;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    hist = {};
    repeat (2) hist.push_back(1'b0);
    cyc = 0; release_at = 0; m_fcnt = 0;
    m_fault = 0; dead = 0; cur = 4'b0000; goal = 4'b0000;
  endtask

  task automatic model_edge(input bit en, p, n, br, input int dt, input bit ext, clr);
    bit         seen, illegal, idle_cmd;
    logic [3:0] want;
    int         dtc;
    exp_t       e;
    seen = hist.pop_front();
    hist.push_back(ext);
    cyc++;
    illegal  = en && p && n;
    idle_cmd = !en || (!p && !n);
    if (!en)            want = 4'b0000;
    else if (p && !n)   want = 4'b1001;
    else if (!p && n)   want = 4'b0110;
    else                want = br ? 4'b0101 : 4'b0000;
    dtc = (dt < 1) ? 1 : dt;
    if (m_fault) begin
      if (clr && !seen && idle_cmd) begin
        m_fault = 0; dead = 1; goal = want; release_at = cyc + dtc;
      end
    end else if (illegal || seen) begin
      m_fault = 1;
      if (m_fcnt < 255) m_fcnt++;
    end else if (dead) begin
      if (want != goal) begin
        goal = want; release_at = cyc + dtc;
      end else if (cyc >= release_at) begin
        dead = 0; cur = goal;
      end
    end else if (want != cur) begin
      dead = 1; goal = want; release_at = cyc + dtc;
    end
    e.g = (m_fault || dead) ? 4'b0000 : cur;
    e.f = m_fault;
    e.c = 8'(m_fcnt);
    exp_q.push_back(e);
  endtask

  // Called on a negedge; drives inputs for the coming posedge and returns on the next negedge.
  task automatic step(input bit en, p, n, br, input int dt, input bit ext, clr);
    enable = en; pos_in = p; neg_in = n; brake_en = br;
    dead_time = 8'(dt); ext_fault = ext; fault_clear = clr;
    model_edge(en, p, n, br, dt, ext, clr);
    @(negedge clk);
  endtask

  task automatic hold(input int cycles, input bit en, p, n, br, input int dt,
                      input bit ext, clr);
    for (int i = 0; i < cycles; i++) step(en, p, n, br, dt, ext, clr);
  endtask

  task automatic mid_reset();
    #2 reset = 1'b1;
    #1 check("async_reset_gates", {gate_ah, gate_al, gate_bh, gate_bl}, 0);
    check("async_reset_fault", fault, 0);
    model_reset();
    exp_q.push_back('0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_on) begin
        check("shoot_through", (gate_ah & gate_al) | (gate_bh & gate_bl), 0);
        if (exp_q.size() == 0) begin
          check("scoreboard_underflow", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("gates", {gate_ah, gate_al, gate_bh, gate_bl}, e.g);
          check("fault", fault, e.f);
          check("fault_count", fault_count, e.c);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench did not finish");
  end

  initial begin : stimulus
    int len, r, dt;
    bit en, p, n, br;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_gates", {gate_ah, gate_al, gate_bh, gate_bl}, 0);
    check("reset_fault_count", fault_count, 0);
    reset = 1'b0;
    mon_on = 1;

    hold(20, 1, 0, 0, 0, 5, 0, 0);            // idle coast
    hold(30, 1, 1, 0, 0, 5, 0, 0);            // forward
    hold(30, 1, 0, 1, 0, 5, 0, 0);            // reverse
    hold(10, 1, 1, 0, 0, 0, 0, 0);            // minimum dead time
    hold(15, 1, 0, 0, 0, 8, 0, 0);
    hold(3, 1, 1, 0, 0, 8, 0, 0);             // change during DEAD
    hold(20, 1, 0, 1, 0, 8, 0, 0);
    hold(15, 1, 1, 0, 0, 3, 0, 0);
    step(1, 1, 1, 0, 3, 0, 0);                // illegal command
    step(1, 1, 0, 0, 3, 0, 1);                // clear ignored
    hold(3, 1, 1, 0, 0, 3, 0, 0);
    step(1, 0, 0, 0, 3, 0, 1);
    hold(10, 1, 0, 0, 0, 3, 0, 0);
    hold(15, 1, 0, 1, 0, 3, 0, 0);
    hold(3, 1, 0, 1, 0, 3, 1, 0);             // overcurrent pulse
    step(1, 0, 0, 0, 3, 0, 1);                // clear while synced flag high
    step(1, 0, 0, 0, 3, 0, 0);
    step(1, 0, 0, 0, 3, 0, 1);
    hold(10, 1, 0, 0, 0, 3, 0, 0);
    for (int i = 0; i < 256; i++) begin
      step(1, 1, 1, 0, 2, 0, 0);
      step(1, 0, 0, 0, 2, 0, 1);
    end
    check("fault_count_saturated", fault_count, 255);
    hold(5, 1, 0, 0, 0, 2, 0, 0);
    hold(15, 1, 0, 0, 1, 4, 0, 0);            // brake
    hold(10, 1, 0, 0, 0, 4, 0, 0);

    for (int s = 0; s < 250; s++) begin
      len = $urandom_range(1, 12);
      r   = $urandom_range(0, 19);
      en  = ($urandom_range(0, 9) != 0);
      br  = $urandom_range(0, 1);
      dt  = $urandom_range(0, 6);
      p   = (r < 7) || (r >= 18);
      n   = ((r >= 7) && (r < 14)) || (r >= 18);
      if (r >= 18) begin
        len = 1; en = 1;
      end
      for (int c = 0; c < len; c++)
        step(en, p, n, br, dt, ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0));
    end
    hold(10, 1, 0, 0, 0, 2, 0, 1);

    hold(15, 1, 1, 0, 0, 3, 0, 0);            // reset mid-forward
    mid_reset();
    hold(10, 1, 1, 0, 0, 3, 0, 0);

    mon_on = 0;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hbridge_deadtime_driver.md
Name: hbridge_deadtime_driver

Overview:
- Downstream stage of the ESC speed loop. Consumes the motor_positive / motor_negative PWM pair and drives the four H-bridge gate signals.
- Inserts programmable dead time on every commutation and blocks shoot-through.
- Latches faults from illegal commands or the external overcurrent comparator.
- Offers coast or low-side brake when idle.

Parameters:
- DT_WIDTH, 8, width of the dead_time input in clk cycles.
- DT_MIN, 1, minimum enforced dead time; dead_time values below this are raised to DT_MIN.
- SYNC_STAGES, 2, flop stages on the asynchronous ext_fault input.
- FCNT_WIDTH, 8, width of the saturating fault counter.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  bridge enable; low forces coast.
- pos_in  input  1  forward PWM command (motor_positive upstream).
- neg_in  input  1  reverse PWM command (motor_negative upstream).
- brake_en  input  1  when 1, the idle state drives both low sides on (brake) instead of coast.
- dead_time  input  DT_WIDTH  dead-time length in clk cycles; sampled on entry to DEAD.
- ext_fault  input  1  asynchronous overcurrent flag, active high.
- fault_clear  input  1  single-cycle request to leave FAULT.
- gate_ah  output  1  phase A high-side gate.
- gate_al  output  1  phase A low-side gate.
- gate_bh  output  1  phase B high-side gate.
- gate_bl  output  1  phase B low-side gate.
- fault  output  1  high while in FAULT.
- fault_count  output  FCNT_WIDTH  number of FAULT entries since reset; saturates at all-ones.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE; all gates 0; fault 0; fault_count 0.
  - dead counter 0; target = IDLE; synchronizer flops 0.
  - While reset is high, all gates are held 0, including mid-PWM.
- Command decode:
  - cmd = {pos_in, neg_in}: 10 = FWD, 01 = REV, 00 = IDLE, 11 = illegal.
  - enable = 0 forces cmd to IDLE and brake off (coast).
- States:
  - IDLE: gates 0000 when brake_en = 0; gate_al = gate_bl = 1 when brake_en = 1.
  - FWD: gate_ah = gate_bl = 1.
  - REV: gate_bh = gate_al = 1.
  - DEAD: all gates 0.
  - FAULT: all gates 0, fault = 1.
- Gate outputs are registered and decoded from the next state, so gates change on the same edge as the state.
- Transitions:
  - Any decoded target that differs from the current conducting/IDLE state moves to DEAD on the next edge.
  - On entry to DEAD: target latches; counter loads max(dead_time, DT_MIN).
  - DEAD decrements once per cycle. When the counter reaches 1, the next edge moves to target.
  - Latency from a cmd change at edge k: gates 0 from edge k+1; new pattern at edge k+1+dt.
  - If cmd changes during DEAD to a different target, target updates and the counter reloads (dead time restarts).
  - If cmd returns to the state that was left, DEAD still completes; the dead interval is never shortened.
  - A change of brake_en while in IDLE counts as a target change (IDLE-coast to IDLE-brake and back go through DEAD).
- Fault:
  - Entry conditions: cmd == 11 sampled in any state, or the synchronized ext_fault = 1. The synchronized flag lags the pin by SYNC_STAGES cycles.
  - Entry takes priority over every other transition.
  - Next edge: state = FAULT, gates 0 immediately (no dead time needed, all gates off), fault = 1, fault_count increments unless saturated.
  - Exit requires all of: fault_clear = 1, synchronized ext_fault = 0, cmd == 00. FAULT then moves to DEAD with target IDLE.
  - fault_clear under any other condition is ignored and not remembered.
- Invariant: gate_ah & gate_al and gate_bh & gate_bl are never 1 on any cycle.

Decomposition:
- Shared package esc_pkg:
  - state encoding constants IDLE / DEAD / FWD / REV / FAULT;
  - 4-bit gate-pattern constants (GATES_OFF, GATES_FWD, GATES_REV, GATES_BRAKE);
  - command code constants.
- One sub-module: esc_sync, a SYNC_STAGES-deep single-bit synchronizer used for ext_fault and reusable for the encoder inputs elsewhere.

Test Plan:
- Reset and idle: reset, then cmd 00, brake_en = 0 -> gates 0000 and fault_count 0 for 20 cycles.
- Forward then reverse: dead_time = 5, cmd 10 then cmd 01 after 30 cycles -> 5 cycles all-off, then gate_bh = gate_al = 1; shoot-through invariant checked every cycle.
- Minimum dead time and command change during DEAD:
  - dead_time = 0 -> dead interval is exactly 1 cycle;
  - dead_time = 8 with cmd 10 -> 01 changing at DEAD cycle 3 -> counter restarts, REV pattern 8 cycles after the change.
- Illegal command: cmd 11 for one cycle while FWD -> next edge gates 0000, fault = 1, fault_count = 1.
  - fault_clear with cmd 10 is ignored.
  - fault_clear with cmd 00 -> DEAD, then IDLE.
- Overcurrent: ext_fault pulses high for 3 cycles in REV -> fault asserted 3 cycles after the rising edge (SYNC_STAGES = 2 plus the registered output).
  - fault_clear while ext_fault is still high is ignored.
  - 256 repeated faults -> fault_count holds 255.
- Brake and reset mid-PWM: brake_en = 1 with cmd 00 -> after DEAD, gate_al = gate_bl = 1.
  - Reset asserted mid-FWD -> gates 0 asynchronously, before the next clk edge.
